// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage
// and the instruction memory.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake
// and presents PC / PC+4 / instruction to the IF/ID register.
module ifetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          cpu_clk,
  input  logic          reset,
  input  logic          PCWrite,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          exc_enter,
  input  logic [31:0]   exc_vector,
  input  logic          eret,
  input  logic [31:0]   epc,
  ifetch_unit_if.master imem,
  output logic          IF_valid,
  output logic [31:0]   IF_PC,
  output logic [31:0]   IF_opcplus4,
  output logic [31:0]   IF_instruction,
  output logic          IF_addr_err,
  output logic          IF_backFromEret
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        eret_pending;
  logic        live;
  logic        redirect;
  logic        misal;
  logic        issue;
  logic        ready;
  logic        present;

  always_comb begin
    redirect = exc_enter | eret | branch_taken;
    if (exc_enter) begin
      target = exc_vector;
    end else if (eret) begin
      target = epc;
    end else begin
      target = branch_target;
    end
  end

  // live keeps imem_req low in the first cycle out of reset
  assign misal = |pc[1:0];
  assign ready = imem.imem_ready;
  assign issue = live & ((state == WAIT) |
                 ((state == FETCH) & ~misal));

  assign present = ~redirect &
    (((state == FETCH) & (misal | ready)) |
     ((state == WAIT) & ready));

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  always_ff @(posedge cpu_clk) begin
    if (!reset) begin
      state           <= FETCH;
      pc              <= RESET_VECTOR;
      live            <= 1'b0;
      eret_pending    <= 1'b0;
      IF_valid        <= 1'b0;
      IF_PC           <= '0;
      IF_opcplus4     <= '0;
      IF_instruction  <= '0;
      IF_addr_err     <= 1'b0;
      IF_backFromEret <= 1'b0;
    end else begin
      live <= 1'b1;
      if (redirect) begin
        pc              <= target;
        IF_valid        <= 1'b0;
        IF_addr_err     <= 1'b0;
        IF_backFromEret <= 1'b0;
        eret_pending    <= ~exc_enter & (eret | eret_pending);
        // a request still in flight must be drained before refetch
        if ((issue | (state == DRAIN)) & ~ready) begin
          state <= DRAIN;
        end else begin
          state <= FETCH;
        end
      end else if (present) begin
        IF_valid        <= 1'b1;
        IF_PC           <= pc;
        IF_opcplus4     <= pc + 32'd4;
        IF_instruction  <= misal ? '0 : imem.imem_rdata;
        IF_addr_err     <= misal;
        IF_backFromEret <= eret_pending;
        eret_pending    <= 1'b0;
        state           <= HOLD;
      end else begin
        unique case (state)
          FETCH: state <= WAIT;
          WAIT:  state <= WAIT;
          HOLD: begin
            if (PCWrite) begin
              pc              <= pc + 32'd4;
              IF_valid        <= 1'b0;
              IF_addr_err     <= 1'b0;
              IF_backFromEret <= 1'b0;
              state           <= FETCH;
            end
          end
          DRAIN: begin
            if (ready) begin
              state <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule
